// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, PC source selects, sequencer state encoding
// and the opcode classifier that routes the EXEC step.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_MEM,
        CLS_BRANCH,
        CLS_WB,
        CLS_ILLEGAL
    } op_class_t;

    // FENCE and SYSTEM fall into CLS_ILLEGAL: this core has no handling for them.
    function automatic op_class_t op_class(input logic [6:0] opcode);
        op_class_t cls;
        case (opcode)
            OPC_LOAD, OPC_STORE:                  cls = CLS_MEM;
            OPC_BRANCH:                           cls = CLS_BRANCH;
            OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR:         cls = CLS_WB;
            default:                              cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control and memory-handshake bundle between the multi-cycle sequencer (master)
// and the surrounding datapath / memory ports (slave).
interface multicycle_sequencer_if;

    logic       run;
    logic [6:0] opcode;
    logic       register_we;
    logic       memory_we;
    logic       branch_taken;
    logic       imem_ack;
    logic       dmem_ack;

    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       retire;
    logic       fault;
    logic [2:0] state_o;

    modport master (
        input  run, opcode, register_we, memory_we, branch_taken, imem_ack, dmem_ack,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire,
               fault, state_o
    );

    modport slave (
        output run, opcode, register_we, memory_we, branch_taken, imem_ack, dmem_ack,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire,
               fault, state_o
    );

endinterface

// File: rtl/seq_timeout_cnt.sv
// Wait-cycle counter shared by the instruction and data memory handshakes; expire
// flags the last permitted waiting cycle so an ack in that cycle still wins.
module seq_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes
// and wait timeout. Define SEQ_ILLEGAL_TRAP_EN to fault on non-base opcodes.
module multicycle_sequencer
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_sequencer_if.master        bus
);

    seq_state_t state;
    seq_state_t state_next;

    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       fault;

    logic       cnt_clear;
    logic       cnt_inc;
    logic       expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // One counter serves both ports: only one wait state can be active at a time.
    // Any state change clears it, so it reads 0 in the first cycle of FETCH or MEM.
    assign cnt_clear = (state_next != state);
    assign cnt_inc   = (state == FETCH) || (state == MEM);

    seq_timeout_cnt #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .expire (expire)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_next = state;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_SEL_PLUS4;
        fault      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.run) state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (expire) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                case (op_class(bus.opcode))
                    CLS_MEM: state_next = MEM;
                    CLS_WB:  state_next = WB;
                    CLS_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_sel     = bus.branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                        state_next = FETCH;
                    end
                    default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        state_next = FAULT;
`else
                        pc_we      = 1'b1;
                        state_next = FETCH;
`endif
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = bus.memory_we;
                if (bus.dmem_ack) begin
                    if (bus.opcode == OPC_STORE) begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (expire) begin
                    state_next = FAULT;
                end
            end
            WB: begin
                rf_we      = bus.register_we;
                pc_we      = 1'b1;
                state_next = FETCH;
                if (bus.opcode == OPC_JAL) begin
                    pc_sel = PC_SEL_IMM;
                end else if (bus.opcode == OPC_JALR) begin
                    pc_sel = PC_SEL_ALU;
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.rf_we    = rf_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.retire   = pc_we;
    assign bus.fault    = fault;
    assign bus.state_o  = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected cycle timelines built from the
// sequencing rules, random ack delays and ack noise, directed corner cases.
`timescale 1ns/1ps
module tb_multicycle_sequencer;
    import rv32i_pkg::*;

    localparam int unsigned TO = 16;
`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int K_LOAD = 0, K_STORE = 1, K_BRANCH = 2, K_WB = 3, K_ILLEGAL = 4;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       retire;
        logic       fault;
        logic [2:0] state;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    obs_t exp_q[$];
    logic ia_q[$];
    logic da_q[$];

    multicycle_sequencer_if bus();

    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int op_kind(input logic [6:0] op);
        if (op == OPC_LOAD)   return K_LOAD;
        if (op == OPC_STORE)  return K_STORE;
        if (op == OPC_BRANCH) return K_BRANCH;
        if (op == OPC_OP || op == OPC_OP_IMM || op == OPC_LUI || op == OPC_AUIPC ||
            op == OPC_JAL || op == OPC_JALR) return K_WB;
        return K_ILLEGAL;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.imem_req = bus.imem_req;
        o.ir_we    = bus.ir_we;
        o.dmem_req = bus.dmem_req;
        o.dmem_we  = bus.dmem_we;
        o.rf_we    = bus.rf_we;
        o.pc_we    = bus.pc_we;
        o.pc_sel   = bus.pc_sel;
        o.retire   = bus.retire;
        o.fault    = bus.fault;
        o.state    = bus.state_o;
        return o;
    endfunction

    function automatic obs_t blank(input seq_state_t st);
        obs_t o;
        o       = '0;
        o.state = st;
        return o;
    endfunction

    task automatic check(input obs_t got, input obs_t exp, input string tag);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (imem_req,ir_we,dmem_req,dmem_we,rf_we,pc_we,pc_sel,retire,fault,state)",
                   tag, got, exp);
        end
    endtask

    task automatic push(input obs_t e, input logic ia, input logic da);
        exp_q.push_back(e);
        ia_q.push_back(ia);
        da_q.push_back(da);
    endtask

    task automatic push_fault();
        obs_t e;
        e       = blank(FAULT);
        e.fault = 1'b1;
        for (int i = 0; i < 3; i++) push(e, 1'($urandom), 1'($urandom));
    endtask

    // Entered at any time; leaves the bench one cycle into FETCH, just after the edge.
    task automatic restart();
        bus.run      = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n        = 1'b0;
        #1;
        check(sample(), blank(IDLE), "reset_async");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        #1;
        check(sample(), blank(IDLE), "idle_after_release");
        @(posedge clk);
        #1;
        check(sample(), blank(IDLE), "idle_run_low");
        bus.run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // di/dd: cycles of wait before the ack (>= TO means it never comes).
    task automatic run_instr(input logic [6:0] op, input int di, input int dd,
                             input logic taken, input logic rwe, input int abort_at,
                             input string name);
        obs_t e;
        int   kind;
        bit   stop;
        bit   aborted;
        kind    = op_kind(op);
        stop    = 1'b0;
        aborted = 1'b0;
        exp_q.delete();
        ia_q.delete();
        da_q.delete();

        for (int i = 0; i < int'(TO) && i <= di; i++) begin
            e          = blank(FETCH);
            e.imem_req = 1'b1;
            e.ir_we    = (i == di);
            push(e, (i == di), 1'($urandom));
        end
        if (di >= int'(TO)) begin
            push_fault();
            stop = 1'b1;
        end

        if (!stop) begin
            push(blank(DECODE), 1'($urandom), 1'($urandom));
            e = blank(EXEC);
            if (kind == K_BRANCH || (kind == K_ILLEGAL && !TRAP)) begin
                e.pc_we  = 1'b1;
                e.retire = 1'b1;
                e.pc_sel = (kind == K_BRANCH && taken) ? 2'b01 : 2'b00;
            end
            push(e, 1'($urandom), 1'($urandom));
            if (kind == K_ILLEGAL && TRAP) begin
                push_fault();
                stop = 1'b1;
            end
        end

        if (!stop && (kind == K_LOAD || kind == K_STORE)) begin
            for (int j = 0; j < int'(TO) && j <= dd; j++) begin
                e          = blank(MEM);
                e.dmem_req = 1'b1;
                e.dmem_we  = (kind == K_STORE);
                if (j == dd && kind == K_STORE) begin
                    e.pc_we  = 1'b1;
                    e.retire = 1'b1;
                end
                push(e, 1'($urandom), (j == dd));
            end
            if (dd >= int'(TO)) begin
                push_fault();
                stop = 1'b1;
            end
        end

        if (!stop && (kind == K_LOAD || kind == K_WB)) begin
            e        = blank(WB);
            e.rf_we  = rwe;
            e.pc_we  = 1'b1;
            e.retire = 1'b1;
            e.pc_sel = (op == OPC_JAL) ? 2'b01 : (op == OPC_JALR) ? 2'b10 : 2'b00;
            push(e, 1'($urandom), 1'($urandom));
        end

        bus.opcode       = op;
        bus.register_we  = rwe;
        bus.memory_we    = (kind == K_STORE);
        bus.branch_taken = taken;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            bus.imem_ack = ia_q[k];
            bus.dmem_ack = da_q[k];
            #1;
            check(sample(), exp_q[k], $sformatf("%s_c%0d", name, k));
            @(posedge clk);
            #1;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (stop || aborted) restart();
    endtask

    initial begin
        logic [6:0] ops [12];
        logic [6:0] op;
        int         di;
        int         dd;

        ops = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                OPC_JAL, OPC_JALR, OPC_BRANCH, 7'b1111111, 7'b0001111, 7'b1110011};

        bus.run          = 1'b0;
        bus.opcode       = '0;
        bus.register_we  = 1'b0;
        bus.memory_we    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.dmem_ack     = 1'b0;
        #2;
        restart();

        // Directed cases.
        run_instr(OPC_OP,     0, 0, 1'b0, 1'b1, -1, "add");
        run_instr(OPC_LOAD,   0, 3, 1'b0, 1'b1, -1, "lw_slow");
        run_instr(OPC_STORE,  0, 0, 1'b0, 1'b0, -1, "sw");
        run_instr(OPC_BRANCH, 0, 0, 1'b1, 1'b0, -1, "beq_taken");
        run_instr(OPC_BRANCH, 0, 0, 1'b0, 1'b0, -1, "beq_not");
        run_instr(OPC_JAL,    0, 0, 1'b0, 1'b1, -1, "jal");
        run_instr(OPC_JALR,   0, 0, 1'b0, 1'b1, -1, "jalr");
        run_instr(OPC_OP_IMM, 0, 0, 1'b0, 1'b0, -1, "addi_x0");
        run_instr(OPC_LOAD,   TO - 1, TO - 1, 1'b0, 1'b1, -1, "ack_last_cycle");
        run_instr(7'b1111111, 1, 0, 1'b0, 1'b1, -1, "illegal");
        run_instr(OPC_LUI,    TO, 0, 1'b0, 1'b1, -1, "imem_timeout");
        run_instr(OPC_STORE,  0, TO, 1'b0, 1'b0, -1, "dmem_timeout");
        run_instr(OPC_LOAD,   0, 8, 1'b0, 1'b1, 5, "reset_in_mem");

        // Random instruction stream with random ack delays.
        for (int n = 0; n < 80; n++) begin
            do begin
                op = ops[$urandom_range(0, 11)];
            end while (TRAP && op_kind(op) == K_ILLEGAL);
            di = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 4));
            dd = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 4));
            run_instr(op, di, dd, 1'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
